// File: rtl/gnrc_arb_pkg.sv
// ============================================================================
// Module      : gnrc_arb_pkg
// Description : Shared helpers for the gnrc arbiter family (index width and
//               round-robin pointer increment).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gnrc_arb_pkg;

    // Width of a source index; never below one bit so 1-entry builds still elaborate.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage : gnrc_arb_pkg

`default_nettype wire

// File: rtl/gnrc_rr_picker.sv
// ============================================================================
// Module      : gnrc_rr_picker
// Description : Combinational rotate-priority picker: first set request at or
//               after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnrc_rr_picker
    import gnrc_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    int w_k;

    // Scan from the farthest offset down so the nearest match to ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = int'(ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (req[w_k]) begin
                gnt_idx = IW'(w_k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule : gnrc_rr_picker

`default_nettype wire

// File: rtl/gnrc_stream_arb.sv
// ============================================================================
// Module      : gnrc_stream_arb
// Description : N-to-1 round-robin valid/ready stream arbiter with a single
//               registered output stage tagging each beat with its source.
//               Optional packet lock: define GNRC_ARB_PKT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gnrc_stream_arb
    import gnrc_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 16,
    localparam int IW = idx_w(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [N-1:0]    valid_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    ready_o,
`ifdef GNRC_ARB_PKT_LOCK_EN
    input  logic [N-1:0]    last_i,
    output logic            last_o,
`endif
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    output logic [IW-1:0]   idx_o,
    input  logic            ready_i
);

    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [IW-1:0]   ptr_q,   ptr_d;

    logic [N-1:0]    w_req;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_gnt_vld;
    logic            w_take;
    logic [DW-1:0]   w_data_arr [N];

    generate
        for (genvar k = 0; k < N; k++) begin : g_unpack
            assign w_data_arr[k] = data_i[k*DW +: DW];
        end
    endgenerate

`ifdef GNRC_ARB_PKT_LOCK_EN
    logic            lock_q,     lock_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic            last_q,     last_d;

    // While a packet is open only its owner may be granted.
    assign w_req = lock_q ? (valid_i & (N'(1) << lock_idx_q)) : valid_i;
`else
    assign w_req = valid_i;
`endif

    gnrc_rr_picker #(
        .N       (N)
    ) u_picker (
        .req     (w_req),
        .ptr     (ptr_q),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // Gating with rst_ni keeps ready_o low while reset is asserted asynchronously.
    assign w_take = rst_ni & w_gnt_vld & (~valid_q | ready_i) & ~flush_i;

    always_comb begin
        ready_o = '0;
        if (w_take) begin
            ready_o[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef GNRC_ARB_PKT_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
            ptr_d   = '0;
`ifdef GNRC_ARB_PKT_LOCK_EN
            lock_d  = 1'b0;
`endif
        end else if (w_take) begin
            valid_d = 1'b1;
            data_d  = w_data_arr[w_gnt_idx];
            idx_d   = w_gnt_idx;
`ifdef GNRC_ARB_PKT_LOCK_EN
            last_d  = last_i[w_gnt_idx];
            if (last_i[w_gnt_idx]) begin
                lock_d = 1'b0;
                ptr_d  = IW'(rr_next(int'(w_gnt_idx), N));
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = w_gnt_idx;
            end
`else
            ptr_d   = IW'(rr_next(int'(w_gnt_idx), N));
`endif
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef GNRC_ARB_PKT_LOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
        end
    end

    assign last_o = last_q;
`endif

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

endmodule : gnrc_stream_arb

`default_nettype wire

// File: tb/tb_gnrc_stream_arb.sv
// ============================================================================
// Module      : tb_gnrc_stream_arb
// Description : Randomized self-checking bench for gnrc_stream_arb against a
//               behavioural round-robin model. Honours GNRC_ARB_PKT_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gnrc_stream_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk     = 1'b0;
    logic            rst_ni  = 1'b0;
    logic            flush_i = 1'b0;
    logic            ready_i = 1'b0;
    logic [N-1:0]    valid_i = '0;
    logic [N*DW-1:0] data_i  = '0;
    logic [N-1:0]    last_i  = '1;
    logic [N-1:0]    ready_o;
    logic            valid_o;
    logic [DW-1:0]   data_o;
    logic [IW-1:0]   idx_o;
    logic            last_o;

    gnrc_stream_arb #(
        .N       (N),
        .DW      (DW)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
`ifdef GNRC_ARB_PKT_LOCK_EN
        .last_i  (last_i),
        .last_o  (last_o),
`endif
        .valid_o (valid_o),
        .data_o  (data_o),
        .idx_o   (idx_o),
        .ready_i (ready_i)
    );

`ifndef GNRC_ARB_PKT_LOCK_EN
    assign last_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model state: the registered output beat plus arbitration memory.
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_idx;
    int            m_ptr;
    bit            m_lock;
    int            m_lock_idx;
    logic          m_last;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_data     = '0;
        m_idx      = 0;
        m_ptr      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        m_last     = 1'b0;
    endtask

    function automatic int pick();
        int k;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (valid_i[k] && (!m_lock || k == m_lock_idx)) return k;
        end
        return -1;
    endfunction

    // One clock: check at negedge, advance the model, return accepted requesters.
    task automatic step(output logic [N-1:0] acc);
        int           g;
        bit           tk;
        logic [N-1:0] er;
        @(negedge clk);
        g  = pick();
        tk = rst_ni && (g >= 0) && (!m_valid || ready_i) && !flush_i;
        er = '0;
        if (tk) er[g] = 1'b1;
        chk("ready_o", ready_o, er);
        chk("valid_o", valid_o, m_valid);
        chk("data_o",  data_o,  m_data);
        chk("idx_o",   idx_o,   m_idx);
`ifdef GNRC_ARB_PKT_LOCK_EN
        chk("last_o",  last_o,  m_last);
`endif
        acc = er;
        if (flush_i) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_lock  = 1'b0;
        end else if (tk) begin
            m_valid = 1'b1;
            m_data  = data_i[g*DW +: DW];
            m_idx   = g;
`ifdef GNRC_ARB_PKT_LOCK_EN
            m_last  = last_i[g];
            if (last_i[g]) begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock     = 1'b1;
                m_lock_idx = g;
            end
`else
            m_ptr   = (g + 1) % N;
`endif
        end else if (m_valid && ready_i) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Refresh requesters that are idle or were just accepted; others hold.
    task automatic gen(input logic [N-1:0] acc, input int pct, input logic [N-1:0] mask,
                       input int last_pct);
        for (int k = 0; k < N; k++) begin
            if (!valid_i[k] || acc[k]) begin
                valid_i[k]         = mask[k] && ($urandom_range(99) < pct);
                data_i[k*DW +: DW] = DW'($urandom);
                last_i[k]          = ($urandom_range(99) < last_pct);
            end
        end
    endtask

    task automatic do_flush();
        logic [N-1:0] acc;
        flush_i = 1'b1;
        step(acc);
        flush_i = 1'b0;
    endtask

    logic [N-1:0] acc;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data",  data_o,  '0);
        chk("rst_idx",   idx_o,   '0);
        chk("rst_ready", ready_o, '0);
        rst_ni = 1'b1;

        // All requesters busy, downstream always ready: 0,1,2,3,0,...
        ready_i = 1'b1;
        acc     = '0;
        gen(acc, 100, 4'b1111, 100);
        for (int i = 0; i < 12; i++) begin
            step(acc);
            gen(acc, 100, 4'b1111, 100);
        end

        // Stall with requesters 1 and 3, then release.
        valid_i = '0;
        do_flush();
        gen('0, 100, 4'b1010, 100);
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            gen(acc, 100, 4'b1010, 100);
        end
        chk("stall_idx", idx_o, 1);
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            gen(acc, 100, 4'b1010, 100);
        end

        // Single requester 2 for six beats, then everyone: pointer must be at 3.
        valid_i = '0;
        do_flush();
        gen('0, 100, 4'b0100, 100);
        for (int i = 0; i < 6; i++) begin
            step(acc);
            gen(acc, 100, 4'b0100, 100);
        end
        chk("single_idx", idx_o, 2);
        gen('0, 100, 4'b1111, 100);
        step(acc);
        chk("single_ptr", idx_o, 3);
        gen(acc, 100, 4'b1111, 100);

        // Flush while a beat is stalled at the output.
        for (int i = 0; i < 3; i++) begin
            step(acc);
            gen(acc, 100, 4'b1111, 100);
        end
        ready_i = 1'b0;
        step(acc);
        gen(acc, 100, 4'b1111, 100);
        flush_i = 1'b1;
        step(acc);
        flush_i = 1'b0;
        chk("flush_valid", valid_o, 1'b0);
        step(acc);
        chk("flush_restart", idx_o, 0);
        ready_i = 1'b1;
        gen(acc, 100, 4'b1111, 100);

        // Asynchronous reset pulse mid-stream.
        for (int i = 0; i < 3; i++) begin
            step(acc);
            gen(acc, 100, 4'b1111, 100);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_data",  data_o,  '0);
        chk("arst_idx",   idx_o,   '0);
        chk("arst_ready", ready_o, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        step(acc);
        chk("arst_restart", idx_o, 0);
        gen(acc, 100, 4'b1111, 100);

`ifdef GNRC_ARB_PKT_LOCK_EN
        // Requester 1 sends a 3-beat packet while requester 0 keeps asking.
        begin
            int exp_idx  [4] = '{1, 1, 1, 0};
            int exp_last [4] = '{0, 0, 1, 1};
            int beats = 0;
            int n     = 0;
            valid_i = '0;
            do_flush();
            valid_i = 4'b0001;
            last_i  = '1;
            step(acc);
            valid_i   = 4'b0011;
            last_i[1] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step(acc);
                if (acc != '0 && n < 4) begin
                    chk("lock_seq_idx",  idx_o,  exp_idx[n]);
                    chk("lock_seq_last", last_o, exp_last[n]);
                    n++;
                end
                if (acc[1]) begin
                    beats++;
                    data_i[1*DW +: DW] = DW'($urandom);
                    last_i[1] = (beats == 2);
                    if (beats == 3) valid_i[1] = 1'b0;
                end
                if (acc[0]) valid_i[0] = 1'b0;
            end
            chk("lock_seq_count", n, 4);
        end
`endif

        // Random soak with backpressure and occasional flushes.
        valid_i = '0;
        for (int i = 0; i < 1500; i++) begin
            ready_i = ($urandom_range(3) != 0);
            flush_i = ($urandom_range(31) == 0);
            step(acc);
            gen(acc, 60, 4'b1111, 50);
        end
        flush_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gnrc_stream_arb

`default_nettype wire
